// File: rtl/md_issue_ctrl_pkg.sv
// md_issue_ctrl_pkg: shared definitions for the multiply/divide issue controller.
// Holds the FSM state encodings, default protocol timeouts and the captured
// request record shared by the controller and its timeout counter.
package md_issue_ctrl_pkg;

  // FSM state encodings (2 bits, kept as plain constants for legacy users)
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_ARM    = 2'd2;
  localparam logic [1:0] ST_WAIT   = 2'd3;

  // Width of the one-hot op field
  localparam int OP_W = 7;

  // Default protocol timeouts and the counter width that must hold them
  localparam int DEF_ARM_TIMEOUT  = 4;
  localparam int DEF_BUSY_TIMEOUT = 16;
  localparam int DEF_CNT_W        = 5;

  // Request captured from ID when an MD op is accepted
  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [31:0]     d1;
    logic [31:0]     d2;
  } md_req_t;

endpackage

// File: rtl/md_timeout_cnt.sv
// md_timeout_cnt: shared protocol-timeout counter.
// Counts enabled cycles since the last clear; hit is asserted on the enabled
// cycle that brings the count up to limit, so the owner can flag the timeout
// on that same edge.
module md_timeout_cnt #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             hit
);

  logic [CNT_W-1:0] count;

  // Count enabled cycles; clear has priority so a new phase always starts at zero
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign hit = enable && ((count + 1'b1) == limit);

endmodule

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: initiator side of the multiply/divide start/busy handshake.
// Accepts decoded MD ops from ID, registers op and operands, pulses md_start
// for one cycle, tracks md_busy and stalls ID for HI/LO users while an op is
// in flight. Protocol timeouts set the sticky md_err flag.
// Optional feature: define MD_FLUSH_EN to add the md_flush input, which
// blocks capture in IDLE, cancels a pending launch and masks stall_id.
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int ARM_TIMEOUT  = DEF_ARM_TIMEOUT,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_md_req,
  input  logic [OP_W-1:0] id_md_op,
  input  logic            id_hilo_use,
  input  logic [31:0]     id_rs_val,
  input  logic [31:0]     id_rt_val,
  input  logic            md_busy,
  output logic            md_start,
  output logic [OP_W-1:0] md_op,
  output logic [31:0]     md_d1,
  output logic [31:0]     md_d2,
  output logic            stall_id,
  output logic            md_err
`ifdef MD_FLUSH_EN
  ,
  input  logic            md_flush
`endif
);

  localparam logic [CNT_W-1:0] ARM_LIM  = CNT_W'(ARM_TIMEOUT);
  localparam logic [CNT_W-1:0] BUSY_LIM = CNT_W'(BUSY_TIMEOUT);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             accept;
  logic             err_set;
  logic             flush_now;
  logic             cnt_clear;
  logic             cnt_enable;
  logic [CNT_W-1:0] cnt_limit;
  logic             cnt_hit;
  md_req_t          req_q;

`ifdef MD_FLUSH_EN
  assign flush_now = md_flush;
`else
  assign flush_now = 1'b0;
`endif

  // Next-state logic for the IDLE -> LAUNCH -> ARM -> WAIT handshake
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    err_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (id_md_req && !flush_now) begin
          accept     = 1'b1;
          state_next = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        state_next = flush_now ? ST_IDLE : ST_ARM;
      end
      ST_ARM: begin
        if (md_busy) begin
          state_next = ST_WAIT;
        end else if (cnt_hit) begin
          err_set    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!md_busy) begin
          state_next = ST_IDLE;
        end else if (cnt_hit) begin
          err_set    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, captured request and sticky error registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      req_q  <= '0;
      md_err <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        req_q.op <= id_md_op;
        req_q.d1 <= id_rs_val;
        req_q.d2 <= id_rt_val;
      end else if (state != ST_IDLE && state_next == ST_IDLE) begin
        req_q.op <= '0;
      end
      if (err_set) begin
        md_err <= 1'b1;
      end
    end
  end

  // One counter serves both the arm wait and the busy wait
  assign cnt_clear  = (state == ST_LAUNCH) || (state == ST_ARM && md_busy);
  assign cnt_enable = (state == ST_ARM && !md_busy) || (state == ST_WAIT && md_busy);
  assign cnt_limit  = (state == ST_ARM) ? ARM_LIM : BUSY_LIM;

  md_timeout_cnt #(
    .CNT_W (CNT_W)
  ) u_timeout_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .limit  (cnt_limit),
    .hit    (cnt_hit)
  );

  assign md_start = (state == ST_LAUNCH) && !flush_now;
  assign md_op    = req_q.op;
  assign md_d1    = req_q.d1;
  assign md_d2    = req_q.d2;
  assign stall_id = (id_md_req || id_hilo_use) && (state != ST_IDLE) && !flush_now;

endmodule
